// File: rtl/ser_rx.sv
// ser_rx: asynchronous-serial frame receiver with a valid/ready output register.
// Frame on the line: start bit (0), WIDTH data bits LSB first, optional parity bit, stop bit (1).
// Optional feature: define SER_RX_PARITY_EN to receive an even-parity bit after the data bits
// and report a mismatch on parity_err_o alongside the delivered word.
module ser_rx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             rx_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             frame_err_o,
`ifdef SER_RX_PARITY_EN
    output logic             parity_err_o,
`endif
    output logic             overrun_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SER_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       sync_q;
    logic             rxs;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] bit_idx;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_next;
    logic             bit_end;
    logic             cnt_clr;
    logic             shift_en;
    logic             stop_sample;
`ifdef SER_RX_PARITY_EN
    logic             par_q;
    logic             par_sample;
    logic             par_bad;
`endif

    assign rxs     = sync_q[1];
    assign bit_end = (cnt == CNT_LAST);

    // Two-flop synchronizer for the asynchronous line; resets to the idle level.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_i};
        end
    end

    // Receive state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and per-cycle sampling strobes.
    always_comb begin
        state_next  = state;
        cnt_clr     = 1'b0;
        shift_en    = 1'b0;
        stop_sample = 1'b0;
`ifdef SER_RX_PARITY_EN
        par_sample  = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (!rxs) begin
                    state_next = START;
                end
            end
            START: begin
                if (cnt == CNT_MID) begin
                    cnt_clr    = 1'b1;
                    state_next = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == IDX_LAST) begin
`ifdef SER_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef SER_RX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_clr    = 1'b1;
                    par_sample = 1'b1;
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    cnt_clr     = 1'b1;
                    stop_sample = 1'b1;
                    state_next  = rxs ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                cnt_clr = 1'b1;
                if (rxs) begin
                    state_next = IDLE;
                end
            end
            default: begin
                cnt_clr    = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    // Oversample counter and data-bit index.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            cnt <= cnt_clr ? '0 : cnt + CNT_W'(1);
            if (state != DATA) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + IDX_W'(1);
            end
        end
    end

    // New sample enters at the MSB so the first bit received ends up at the LSB.
    always_comb begin
        shift_next            = shift_q >> 1;
        shift_next[WIDTH-1]   = rxs;
    end

    // Data shift register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            shift_q <= '0;
        end else if (shift_en) begin
            shift_q <= shift_next;
        end
    end

`ifdef SER_RX_PARITY_EN
    assign par_bad = ^{shift_q, par_q};

    // Captured parity bit; even parity across data plus this bit is expected.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            par_q <= 1'b0;
        end else if (par_sample) begin
            par_q <= rxs;
        end
    end
`endif

    // Output register: deliver, drop with overrun, or consume; flags are single-cycle pulses.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_o       <= '0;
            valid_o      <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
`ifdef SER_RX_PARITY_EN
            parity_err_o <= 1'b0;
`endif
        end else begin
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
            if (stop_sample && rxs) begin
                if (!valid_o || ready_i) begin
                    data_o       <= shift_q;
                    valid_o      <= 1'b1;
`ifdef SER_RX_PARITY_EN
                    parity_err_o <= par_bad;
`endif
                end else begin
                    overrun_o <= 1'b1;
                end
            end else begin
                frame_err_o <= stop_sample;
                if (valid_o && ready_i) begin
                    valid_o      <= 1'b0;
`ifdef SER_RX_PARITY_EN
                    parity_err_o <= 1'b0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_ser_rx.sv
// tb_ser_rx: directed and randomized frames against a frame-level reference model.
// Build with SER_RX_PARITY_EN defined to exercise the parity bit and parity_err_o.
module tb_ser_rx;

    localparam int WIDTH    = 8;
    localparam int CPB      = 16;
    localparam int LAT_BASE = 3 + CPB / 2 - 1 + (WIDTH + 1) * CPB + 1;
`ifdef SER_RX_PARITY_EN
    localparam int LAT = LAT_BASE + CPB;
`else
    localparam int LAT = LAT_BASE;
`endif

    logic             clk_i   = 1'b0;
    logic             rst_n_i = 1'b0;
    logic             rx_i    = 1'b1;
    logic             ready_i = 1'b1;
    logic [WIDTH-1:0] data_o;
    logic             valid_o;
    logic             frame_err_o;
    logic             overrun_o;
`ifdef SER_RX_PARITY_EN
    logic             parity_err_o;
    logic             frame_par = 1'b0;
    logic             last_perr = 1'b0;
    logic             exp_perr  = 1'b0;
`endif

    int check_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    // Observed events, collected by the monitor.
    int               cyc       = 0;
    int               deliv_cnt = 0;
    int               ferr_cnt  = 0;
    int               ovr_cnt   = 0;
    int               both_cnt  = 0;
    int               last_cyc  = 0;
    logic [WIDTH-1:0] last_data = '0;
    logic             prev_valid = 1'b0;
    logic             prev_ready = 1'b0;

    // Frame-level reference model state.
    int               exp_deliv  = 0;
    int               exp_ferr   = 0;
    int               exp_ovr    = 0;
    logic [WIDTH-1:0] exp_data   = '0;
    bit               model_full = 1'b0;
    int               start_cyc  = 0;

    ser_rx #(
        .WIDTH        (WIDTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .rx_i         (rx_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .frame_err_o  (frame_err_o),
`ifdef SER_RX_PARITY_EN
        .parity_err_o (parity_err_o),
`endif
        .overrun_o    (overrun_o)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk_i = ~clk_i;

    // Edge counter used for latency measurement.
    always @(posedge clk_i) cyc++;

    // Monitor on the falling edge: count flag pulses and record each newly presented word.
    always @(negedge clk_i) begin
        if (frame_err_o) ferr_cnt++;
        if (overrun_o) ovr_cnt++;
        if (frame_err_o && overrun_o) both_cnt++;
        if (valid_o && (!prev_valid || prev_ready)) begin
            deliv_cnt++;
            last_data = data_o;
            last_cyc  = cyc;
`ifdef SER_RX_PARITY_EN
            last_perr = parity_err_o;
`endif
        end
        prev_valid = valid_o;
        prev_ready = ready_i;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, leaving inputs to change 2 units after the edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #2;
        end
    endtask

    // Drive one complete frame; the stop level is held for CPB + hold clocks, then the line idles high.
    task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic stop, input int hold);
        rx_i      = 1'b0;
        start_cyc = cyc + 1;
        tick(CPB);
        for (int i = 0; i < WIDTH; i++) begin
            rx_i = data[i];
            tick(CPB);
        end
`ifdef SER_RX_PARITY_EN
        rx_i = frame_par;
        tick(CPB);
`endif
        rx_i = stop;
        tick(CPB + hold);
        rx_i = 1'b1;
    endtask

    // Reference model: what one frame should produce given the current ready level.
    task automatic modelFrame(input logic [WIDTH-1:0] data, input logic stop, output bit delivered);
        delivered = 1'b0;
        if (!stop) begin
            exp_ferr++;
        end else if (model_full && !ready_i) begin
            exp_ovr++;
        end else begin
            exp_deliv++;
            exp_data   = data;
            model_full = !ready_i;
            delivered  = 1'b1;
`ifdef SER_RX_PARITY_EN
            exp_perr = ((($countones(data) + int'(frame_par)) % 2) == 1);
`endif
        end
    endtask

    task automatic sendAndCheck(input string tag, input logic [WIDTH-1:0] data, input logic stop,
                                input int hold);
        bit delivered;
        int lat;
        modelFrame(data, stop, delivered);
        applyStimulus(data, stop, hold);
        tick(4);
        checkOutput({tag, "_deliv"}, deliv_cnt, exp_deliv);
        checkOutput({tag, "_ferr"}, ferr_cnt, exp_ferr);
        checkOutput({tag, "_ovr"}, ovr_cnt, exp_ovr);
        if (delivered) begin
            lat = last_cyc - start_cyc;
            checkOutput({tag, "_data"}, last_data, exp_data);
            checkOutput({tag, "_lat"}, (lat >= LAT - 1 && lat <= LAT + 1), 1);
`ifdef SER_RX_PARITY_EN
            checkOutput({tag, "_perr"}, last_perr, exp_perr);
`endif
        end
    endtask

    initial begin
        logic [WIDTH-1:0] rdata;
        logic             rstop;

        // Reset state.
        tick(3);
        #1;
        checkOutput("rst_data", data_o, 0);
        checkOutput("rst_valid", valid_o, 0);
        checkOutput("rst_ferr", frame_err_o, 0);
        checkOutput("rst_ovr", overrun_o, 0);
`ifdef SER_RX_PARITY_EN
        checkOutput("rst_perr", parity_err_o, 0);
`endif
        rst_n_i = 1'b1;
        tick(4);

        // Basic frame; valid lasts one cycle since ready is high.
        sendAndCheck("a5", 8'hA5, 1'b1, 0);
        checkOutput("a5_valid_gone", valid_o, 0);

        // Short low glitch must be rejected without flags.
        rx_i = 1'b0;
        tick(4);
        rx_i = 1'b1;
        tick(2 * CPB);
        checkOutput("glitch_deliv", deliv_cnt, exp_deliv);
        checkOutput("glitch_ferr", ferr_cnt, exp_ferr);
        sendAndCheck("3c", 8'h3C, 1'b1, 0);

        // Bad stop bit with a long low line: one error, no retrigger while low.
        sendAndCheck("81", 8'h81, 1'b0, 40);
        checkOutput("81_valid", valid_o, 0);
        tick(CPB * (WIDTH + 3));
        checkOutput("81_no_restart", deliv_cnt, exp_deliv);
        checkOutput("81_one_err", ferr_cnt, exp_ferr);
        sendAndCheck("42", 8'h42, 1'b1, 0);

        // Output held full: second word dropped with overrun, first word stays.
        ready_i = 1'b0;
        sendAndCheck("11", 8'h11, 1'b1, 0);
        tick(5);
        sendAndCheck("22", 8'h22, 1'b1, 0);
        checkOutput("ovr_data", data_o, 8'h11);
        checkOutput("ovr_valid", valid_o, 1);
        ready_i    = 1'b1;
        model_full = 1'b0;
        tick(1);
        checkOutput("consume_valid", valid_o, 0);
        tick(3);

        // Asynchronous reset in the middle of a frame.
        rx_i = 1'b0;
        tick(CPB);
        rx_i = 1'b1;
        tick(CPB);
        rx_i = 1'b0;
        tick(CPB);
        rx_i = 1'b1;
        tick(CPB);
        rst_n_i = 1'b0;
        #1;
        checkOutput("midrst_data", data_o, 0);
        checkOutput("midrst_valid", valid_o, 0);
        checkOutput("midrst_ferr", frame_err_o, 0);
        checkOutput("midrst_ovr", overrun_o, 0);
        model_full = 1'b0;
        tick(3);
        rst_n_i = 1'b1;
        tick(3);
        sendAndCheck("ff", 8'hFF, 1'b1, 0);

        // Randomized frames with occasional bad stop bits.
        for (int n = 0; n < 10; n++) begin
            rdata = WIDTH'($urandom);
            rstop = ($urandom_range(0, 4) != 0);
`ifdef SER_RX_PARITY_EN
            frame_par = 1'($urandom);
`endif
            sendAndCheck("rand", rdata, rstop, 0);
            tick($urandom_range(2, 12));
        end

`ifdef SER_RX_PARITY_EN
        // Parity: 0x07 has three ones, so parity bit 1 is correct and 0 is wrong.
        frame_par = 1'b1;
        sendAndCheck("par_ok", 8'h07, 1'b1, 0);
        checkOutput("par_ok_flag", last_perr, 0);
        frame_par = 1'b0;
        sendAndCheck("par_bad", 8'h07, 1'b1, 0);
        checkOutput("par_bad_flag", last_perr, 1);
`endif

        checkOutput("no_simul_flags", both_cnt, 0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
